// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the instruction-cycle control sequencer:
// state encodings, opcode constants and instruction-register field positions.
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_HALT  = 4'd7
    } state_e;

    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_ALU_LO = 5'b00011;
    localparam logic [4:0] OP_ALU_HI = 5'b01011;
    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_HALT   = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    // Register-register ALU opcodes occupy one contiguous range.
    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
    endfunction

endpackage

// File: rtl/control_sequencer_reg_field_decoder.sv
// Turns a 4-bit register-number field into a one-hot 16-bit select,
// all zero when not enabled so unused phases never touch the register file.
module reg_field_decoder (
    input  logic [3:0]  field_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    // One-hot decode gated by enable
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[field_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch / decode / execute sequencer for a simple register-register CPU.
// Moore-style controller: outputs decode from current state and IR contents,
// with the single exception of PC_enable, which tracks mem_ready inside T1.
//
// state  | meaning
// -------+-----------------------------------------------------------
// RESET  | held in reset / first cycle after release, outputs quiet
// T0     | PC -> MAR, compute PC+1 into Z
// T1     | memory read; wait here for mem_ready, load PC from Z
// T2     | MDR -> IR
// T3     | decode; ALU op drives rb into Y, HALT/NOP resolved here
// T4     | rc through ALU into Z
// T5     | Z -> ra, instruction boundary
// HALT   | stopped until reset
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_Data,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PC_select,
    output logic        PC_enable,
    output logic        PC_increment_enable,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        MDR_select,
    output logic        read,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        Z_LO_select,
    output logic [4:0]  alu_instruction,
    output logic [15:0] reg_select,
    output logic [15:0] reg_enable,
    output logic        run,
    output logic [3:0]  state_dbg
);

    state_e      state_q, state_d;
    logic        stop_q, stop_d;

    logic [4:0]  opcode;
    logic        alu_op;
    logic [15:0] rb_onehot, rc_onehot, ra_onehot;
    logic        unused_ir_bits;

    assign opcode         = IR_Data[OPC_MSB:OPC_LSB];
    assign alu_op         = is_alu_op(opcode);
    assign unused_ir_bits = ^IR_Data[RC_LSB-1:0];

    // State and stop-request registers, reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state and stop latch; halting only happens at an instruction boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_T0;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                if (alu_op) begin
                    state_d = ST_T4;
                end else if (opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = stop_q ? ST_HALT : ST_T0;
                end
            end
            ST_T4:    state_d = ST_T5;
            ST_T5:    state_d = stop_q ? ST_HALT : ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RESET;
        endcase
        stop_d = (stop_q | stop) & (state_d != ST_HALT);
    end

    // Per-state datapath strobes
    always_comb begin
        PC_select           = 1'b0;
        PC_enable           = 1'b0;
        PC_increment_enable = 1'b0;
        MAR_enable          = 1'b0;
        MDR_enable          = 1'b0;
        MDR_select          = 1'b0;
        read                = 1'b0;
        IR_enable           = 1'b0;
        Y_enable            = 1'b0;
        Z_enable            = 1'b0;
        Z_LO_select         = 1'b0;
        alu_instruction     = 5'b00000;
        run                 = (state_q != ST_RESET) && (state_q != ST_HALT);
        unique case (state_q)
            ST_T0: begin
                PC_select           = 1'b1;
                MAR_enable          = 1'b1;
                PC_increment_enable = 1'b1;
                Z_enable            = 1'b1;
            end
            ST_T1: begin
                Z_LO_select = 1'b1;
                read        = 1'b1;
                MDR_enable  = 1'b1;
                PC_enable   = mem_ready;
            end
            ST_T2: begin
                MDR_select = 1'b1;
                IR_enable  = 1'b1;
            end
            ST_T3: begin
                Y_enable = alu_op;
            end
            ST_T4: begin
                alu_instruction = opcode;
                Z_enable        = 1'b1;
            end
            ST_T5: begin
                Z_LO_select = 1'b1;
            end
            default: ;
        endcase
    end

    reg_field_decoder u_rb_dec (
        .field_i  (IR_Data[RB_MSB:RB_LSB]),
        .en_i     ((state_q == ST_T3) && alu_op),
        .onehot_o (rb_onehot)
    );

    reg_field_decoder u_rc_dec (
        .field_i  (IR_Data[RC_MSB:RC_LSB]),
        .en_i     (state_q == ST_T4),
        .onehot_o (rc_onehot)
    );

    reg_field_decoder u_ra_dec (
        .field_i  (IR_Data[RA_MSB:RA_LSB]),
        .en_i     (state_q == ST_T5),
        .onehot_o (ra_onehot)
    );

    // rb and rc decoders are never enabled in the same state
    assign reg_select = rb_onehot | rc_onehot;
    assign reg_enable = ra_onehot;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a vector table walks several complete
// instructions, then hand-written sequences cover stop, HALT and mid-cycle reset.
module tb_control_sequencer;

    localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
                           S_T3 = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_HALT = 4'd7;

    localparam logic [10:0] B_PCS  = 11'h400, B_PCE  = 11'h200, B_PCI  = 11'h100,
                            B_MAR  = 11'h080, B_MDRE = 11'h040, B_MDRS = 11'h020,
                            B_READ = 11'h010, B_IRE  = 11'h008, B_Y    = 11'h004,
                            B_Z    = 11'h002, B_ZLO  = 11'h001;
    localparam logic [10:0] C_T0  = B_PCS | B_PCI | B_MAR | B_Z;
    localparam logic [10:0] C_T1  = B_ZLO | B_READ | B_MDRE;
    localparam logic [10:0] C_T1P = C_T1 | B_PCE;
    localparam logic [10:0] C_T2  = B_MDRS | B_IRE;

    localparam logic [31:0] IR_A = 32'h18228000;                          // ADD r0,r4,r5
    localparam logic [31:0] IR_B = {5'b01011, 4'd9, 4'd9, 4'd9, 15'd0};   // top ALU op, ra=rb=rc
    localparam logic [31:0] IR_F = {5'b00110, 4'd15, 4'd0, 4'd8, 15'd0};  // edge register numbers
    localparam logic [31:0] IR_C = {5'b11111, 4'd3, 4'd3, 4'd3, 15'd0};   // unsupported
    localparam logic [31:0] IR_D = {5'b00010, 4'd1, 4'd2, 4'd3, 15'd0};   // just below ALU range
    localparam logic [31:0] IR_E = {5'b01100, 4'd1, 4'd2, 4'd3, 15'd0};   // just above ALU range
    localparam logic [31:0] IR_H = {5'b11011, 4'd0, 4'd0, 4'd0, 15'd0};   // HALT

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_Data;
    logic        mem_ready;
    logic        stop;
    logic        PC_select, PC_enable, PC_increment_enable, MAR_enable, MDR_enable;
    logic        MDR_select, read, IR_enable, Y_enable, Z_enable, Z_LO_select;
    logic [4:0]  alu_instruction;
    logic [15:0] reg_select, reg_enable;
    logic        run;
    logic [3:0]  state_dbg;
    logic [10:0] ctrl;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] ir;
        logic        mem;
        logic [3:0]  st;
        logic [10:0] ctrl;
        logic [4:0]  alu;
        logic [15:0] rsel;
        logic [15:0] ren;
        logic        run;
    } vec_t;

    vec_t vecs[$];

    control_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .IR_Data             (IR_Data),
        .mem_ready           (mem_ready),
        .stop                (stop),
        .PC_select           (PC_select),
        .PC_enable           (PC_enable),
        .PC_increment_enable (PC_increment_enable),
        .MAR_enable          (MAR_enable),
        .MDR_enable          (MDR_enable),
        .MDR_select          (MDR_select),
        .read                (read),
        .IR_enable           (IR_enable),
        .Y_enable            (Y_enable),
        .Z_enable            (Z_enable),
        .Z_LO_select         (Z_LO_select),
        .alu_instruction     (alu_instruction),
        .reg_select          (reg_select),
        .reg_enable          (reg_enable),
        .run                 (run),
        .state_dbg           (state_dbg)
    );

    assign ctrl = {PC_select, PC_enable, PC_increment_enable, MAR_enable, MDR_enable,
                   MDR_select, read, IR_enable, Y_enable, Z_enable, Z_LO_select};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] st, input logic [10:0] c,
                         input logic [4:0] a, input logic [15:0] rs, input logic [15:0] re,
                         input logic r);
        total++;
        if (state_dbg === st && ctrl === c && alu_instruction === a &&
            reg_select === rs && reg_enable === re && run === r) begin
            passed++;
        end else begin
            $display("FAIL %s: got st=%0d ctrl=%b alu=%b rsel=%h ren=%h run=%b; want st=%0d ctrl=%b alu=%b rsel=%h ren=%h run=%b",
                     name, state_dbg, ctrl, alu_instruction, reg_select, reg_enable, run,
                     st, c, a, rs, re, r);
        end
    endtask

    // Advance one clock and check in the middle of the low phase.
    task automatic step_check(input string name, input logic [3:0] st, input logic [10:0] c,
                              input logic [4:0] a, input logic [15:0] rs, input logic [15:0] re,
                              input logic r);
        @(negedge clk);
        #1;
        check(name, st, c, a, rs, re, r);
    endtask

    task automatic v(input logic [31:0] ir, input logic mem, input logic [3:0] st,
                     input logic [10:0] c, input logic [4:0] a, input logic [15:0] rs,
                     input logic [15:0] re, input logic r);
        vec_t e;
        e.ir = ir; e.mem = mem; e.st = st; e.ctrl = c;
        e.alu = a; e.rsel = rs; e.ren = re; e.run = r;
        vecs.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        IR_Data   = '0;
        mem_ready = 1'b0;
        stop      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", S_RESET, '0, '0, '0, '0, 1'b0);

        // ADD r0 <- r4 + r5 with three memory wait cycles
        v(IR_A, 0, S_RESET, '0,    '0,       '0,       '0,       0);
        v(IR_A, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);
        v(IR_A, 0, S_T1,    C_T1,  '0,       '0,       '0,       1);
        v(IR_A, 0, S_T1,    C_T1,  '0,       '0,       '0,       1);
        v(IR_A, 0, S_T1,    C_T1,  '0,       '0,       '0,       1);
        v(IR_A, 1, S_T1,    C_T1P, '0,       '0,       '0,       1);
        v(IR_A, 0, S_T2,    C_T2,  '0,       '0,       '0,       1);
        v(IR_A, 0, S_T3,    B_Y,   '0,       16'h0010, '0,       1);
        v(IR_A, 0, S_T4,    B_Z,   5'b00011, 16'h0020, '0,       1);
        v(IR_A, 0, S_T5,    B_ZLO, '0,       '0,       16'h0001, 1);
        // top-of-range ALU op, ra=rb=rc=9
        v(IR_B, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);
        v(IR_B, 1, S_T1,    C_T1P, '0,       '0,       '0,       1);
        v(IR_B, 0, S_T2,    C_T2,  '0,       '0,       '0,       1);
        v(IR_B, 0, S_T3,    B_Y,   '0,       16'h0200, '0,       1);
        v(IR_B, 0, S_T4,    B_Z,   5'b01011, 16'h0200, '0,       1);
        v(IR_B, 0, S_T5,    B_ZLO, '0,       '0,       16'h0200, 1);
        // ra=15, rb=0, rc=8
        v(IR_F, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);
        v(IR_F, 1, S_T1,    C_T1P, '0,       '0,       '0,       1);
        v(IR_F, 0, S_T2,    C_T2,  '0,       '0,       '0,       1);
        v(IR_F, 0, S_T3,    B_Y,   '0,       16'h0001, '0,       1);
        v(IR_F, 0, S_T4,    B_Z,   5'b00110, 16'h0100, '0,       1);
        v(IR_F, 0, S_T5,    B_ZLO, '0,       '0,       16'h8000, 1);
        // unsupported opcode 11111 behaves as NOP
        v(IR_C, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);
        v(IR_C, 1, S_T1,    C_T1P, '0,       '0,       '0,       1);
        v(IR_C, 0, S_T2,    C_T2,  '0,       '0,       '0,       1);
        v(IR_C, 0, S_T3,    '0,    '0,       '0,       '0,       1);
        // opcode 00010, below ALU range
        v(IR_D, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);
        v(IR_D, 1, S_T1,    C_T1P, '0,       '0,       '0,       1);
        v(IR_D, 0, S_T2,    C_T2,  '0,       '0,       '0,       1);
        v(IR_D, 0, S_T3,    '0,    '0,       '0,       '0,       1);
        // opcode 01100, above ALU range
        v(IR_E, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);
        v(IR_E, 1, S_T1,    C_T1P, '0,       '0,       '0,       1);
        v(IR_E, 0, S_T2,    C_T2,  '0,       '0,       '0,       1);
        v(IR_E, 0, S_T3,    '0,    '0,       '0,       '0,       1);
        v(IR_E, 0, S_T0,    C_T0,  '0,       '0,       '0,       1);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            IR_Data   = vecs[i].ir;
            mem_ready = vecs[i].mem;
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].alu,
                  vecs[i].rsel, vecs[i].ren, vecs[i].run);
            @(negedge clk);
        end

        // stop pulsed in T1: the ADD still completes, then HALT
        IR_Data   = IR_A;
        mem_ready = 1'b1;
        do_reset();
        step_check("stop_t0", S_T0, C_T0, '0, '0, '0, 1'b1);
        step_check("stop_t1", S_T1, C_T1P, '0, '0, '0, 1'b1);
        stop = 1'b1;
        step_check("stop_t2", S_T2, C_T2, '0, '0, '0, 1'b1);
        stop = 1'b0;
        step_check("stop_t3", S_T3, B_Y, '0, 16'h0010, '0, 1'b1);
        step_check("stop_t4", S_T4, B_Z, 5'b00011, 16'h0020, '0, 1'b1);
        step_check("stop_t5", S_T5, B_ZLO, '0, '0, 16'h0001, 1'b1);
        step_check("stop_halt", S_HALT, '0, '0, '0, '0, 1'b0);
        step_check("stop_halt_hold", S_HALT, '0, '0, '0, '0, 1'b0);

        // HALT opcode: halt after T3 and stay put for 10 cycles
        IR_Data = IR_H;
        do_reset();
        step_check("halt_t0", S_T0, C_T0, '0, '0, '0, 1'b1);
        step_check("halt_t1", S_T1, C_T1P, '0, '0, '0, 1'b1);
        step_check("halt_t2", S_T2, C_T2, '0, '0, '0, 1'b1);
        step_check("halt_t3", S_T3, '0, '0, '0, '0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            mem_ready = k[0];
            IR_Data   = (k < 5) ? IR_H : IR_A;
            step_check($sformatf("halt_hold%0d", k), S_HALT, '0, '0, '0, '0, 1'b0);
        end

        // reset in the middle of T4: outputs drop at once, no write-back follows
        IR_Data   = IR_A;
        mem_ready = 1'b1;
        do_reset();
        step_check("rst_t0", S_T0, C_T0, '0, '0, '0, 1'b1);
        step_check("rst_t1", S_T1, C_T1P, '0, '0, '0, 1'b1);
        step_check("rst_t2", S_T2, C_T2, '0, '0, '0, 1'b1);
        step_check("rst_t3", S_T3, B_Y, '0, 16'h0010, '0, 1'b1);
        step_check("rst_t4", S_T4, B_Z, 5'b00011, 16'h0020, '0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", S_RESET, '0, '0, '0, '0, 1'b0);
        step_check("rst_held", S_RESET, '0, '0, '0, '0, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_released", S_RESET, '0, '0, '0, '0, 1'b0);
        step_check("rst_then_t0", S_T0, C_T0, '0, '0, '0, 1'b1);
        step_check("rst_then_t1", S_T1, C_T1P, '0, '0, '0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces state RESET immediately.
REQ-003 SHALL have port: IR_Data  input  32  current instruction register contents; [31:27] opcode, [26:23] ra, [22:19] rb, [18:15] rc.
REQ-004 SHALL have port: mem_ready  input  1  memory read data valid on MDataIN this cycle.
REQ-005 SHALL have port: stop  input  1  request to halt at next instruction boundary.
REQ-006 SHALL have outputs (1 bit each): PC_select, PC_enable, PC_increment_enable, MAR_enable, MDR_enable, MDR_select, read, IR_enable, Y_enable, Z_enable, Z_LO_select.
REQ-007 SHALL have port: alu_instruction  output  5  ALU opcode driven to datapath.
REQ-008 SHALL have port: reg_select  output  16  one-hot general-register bus-drive select (bit n = Rn).
REQ-009 SHALL have port: reg_enable  output  16  one-hot general-register write enable.
REQ-010 SHALL have port: run  output  1  high while not halted.
REQ-011 SHALL have port: state_dbg  output  4  current state encoding, for bench.

Function
REQ-012 SHALL be a Moore FSM; all outputs decode from current state and IR_Data only; unlisted outputs 0 in every state.
REQ-013 SHALL implement states RESET, T0, T1, T2, T3, T4, T5, HALT.
REQ-014 RESET: all outputs 0, run=0; next state T0.
REQ-015 T0: PC_select, MAR_enable, PC_increment_enable, Z_enable =1, alu_instruction=00000; next T1.
REQ-016 T1: Z_LO_select, read, MDR_enable =1; PC_enable=1 only in the cycle mem_ready=1; stay in T1 while mem_ready=0; advance to T2 when mem_ready=1.
REQ-017 T2: MDR_select, IR_enable =1; next T3.
REQ-018 T3 (decode uses IR loaded in T2): if opcode is ALU R-type (00011..01011 inclusive), reg_select bit rb=1, Y_enable=1, next T4; if opcode=HALT (11011) next HALT; any other opcode is a NOP: no outputs, next T0 (or HALT if stop latched).
REQ-019 T4: reg_select bit rc=1, alu_instruction=IR[31:27], Z_enable=1; next T5.
REQ-020 T5: Z_LO_select=1, reg_enable bit ra=1; next T0, or HALT if stop latched.
REQ-021 stop SHALL be latched when sampled high in any state and cleared on entering HALT; halt taken only at T3-NOP or T5 exit, never mid-instruction.
REQ-022 HALT: all outputs 0, run=0; remain until reset.
REQ-023 reg_select and reg_enable SHALL never have more than one bit set; both 0 outside T3/T4 and T5 respectively.
REQ-024 ra=rb=rc permitted; no special casing.
REQ-025 Fetch-to-writeback latency for ALU R-type SHALL be 6 cycles plus (mem_ready wait cycles).

Reset
REQ-026 reset SHALL asynchronously set state=RESET, clear stop latch, and force every output to 0 within the same cycle.
REQ-027 reset asserted mid-instruction SHALL abandon the instruction with no register write; first post-release edge enters T0.

Structure
REQ-028 Shared package SHALL hold state encodings, opcode constants (ADD=00011, ALU range 00011..01011, NOP, HALT=11011), and IR field bit positions.
REQ-029 One sub-module natural: reg_field_decoder (4-bit field -> 16-bit one-hot with enable), instantiated for rb/rc select and ra enable.

Verification
REQ-030 IR=0x18228000, mem_ready=1 in T1 -> T3 reg_select=0x0010 and Y_enable; T4 reg_select=0x0020, alu_instruction=00011, Z_enable; T5 Z_LO_select, reg_enable=0x0001.
REQ-031 mem_ready low 3 cycles in T1 -> state holds T1 with read=1, PC_enable=0; PC_enable pulses one cycle when mem_ready rises; then T2.
REQ-032 IR opcode 11011 -> HALT after T3, run=0, outputs all 0 for 10 cycles.
REQ-033 stop pulsed during T1 of an ADD -> instruction completes through T5, then HALT.
REQ-034 reset asserted mid-T4 -> outputs 0 immediately, no reg_enable pulse, T0 after release.
REQ-035 IR opcode 11111 (unsupported) -> T0 follows T3, reg_enable stays 0x0000.
